// File: rtl/adc_serial_responder.sv
// ---------------------------------------------------------------------------
// adc_serial_responder
//
// Far-end model of an ADC's serial control and calibration pins. Write
// frames arrive on Sclk/Sdata/Select and are decoded into a 16x16 register
// file. A rising Cal level is answered with a delayed, fixed-length
// CalRunning pulse. PD aborts a calibration in progress and blocks frames.
//
// Ports
//   Clock       in   1   system clock, rising edge
//   Reset       in   1   synchronous, active-low reset
//   InSclk      in   1   serial clock (asynchronous to Clock)
//   InSdata     in   1   serial data, MSB first
//   InSelect    in   1   frame select, active low
//   InCal       in   1   calibration request level
//   InPD        in   1   power-down level
//   RdAddr      in   4   register-file read address
//   RdData      out  16  registered reg[RdAddr], one cycle latency
//   RegWrite    out  1   one-cycle strobe when a frame commits
//   RegAddr     out  4   address of the last committed frame
//   RegData     out  16  data of the last committed frame
//   FrameError  out  1   one-cycle strobe when a frame is rejected
//   CalRunning  out  1   high while the modelled calibration runs
// ---------------------------------------------------------------------------
module adc_serial_responder #(
    parameter logic [11:0] HEADER     = 12'h001,
    parameter int unsigned CAL_DELAY  = 4,
    parameter int unsigned CAL_CYCLES = 10
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        InSclk,
    input  logic        InSdata,
    input  logic        InSelect,
    input  logic        InCal,
    input  logic        InPD,
    input  logic [3:0]  RdAddr,
    output logic [15:0] RdData,
    output logic        RegWrite,
    output logic [3:0]  RegAddr,
    output logic [15:0] RegData,
    output logic        FrameError,
    output logic        CalRunning
);

    // Bit positions of the pins inside the synchronizer vectors
    localparam int SCLK   = 0;
    localparam int SDATA  = 1;
    localparam int SELECT = 2;
    localparam int CAL    = 3;
    localparam int PD     = 4;

    // Last count values of the calibration timers
    localparam logic [7:0]  WAIT_LAST = 8'(CAL_DELAY - 1);
    localparam logic [15:0] RUN_LAST  = 16'(CAL_CYCLES - 1);

    typedef enum logic [1:0] {
        F_IDLE,
        F_SHIFT,
        F_CHECK
    } frameState_e;

    typedef enum logic [1:0] {
        CAL_IDLE,
        CAL_WAIT,
        CAL_RUN
    } calState_e;

    logic [4:0]  pinsIn;
    logic [4:0]  sync1_q;
    logic [4:0]  sync2_q;
    // History flops exist only for the pins whose edges are used
    logic [2:0]  hist_q;

    logic        sclkRise;
    logic        selectFall;
    logic        selectRise;
    logic        calRise;
    logic        sdataLevel;
    logic        pdLevel;

    frameState_e frameState_q;
    logic [31:0] shifter_q;
    logic [5:0]  bitCount_q;
    logic [5:0]  bitCount_d;
    logic [15:0] regFile_q [16];
    logic        regWrite_q;
    logic [3:0]  regAddr_q;
    logic [15:0] regData_q;
    logic        frameError_q;
    logic [15:0] rdData_q;

    calState_e   calState_q;
    logic [7:0]  waitCount_q;
    logic [15:0] runCount_q;
    logic        calRunning_q;

    assign pinsIn = {InPD, InCal, InSelect, InSdata, InSclk};

    // Two-flop synchronizers for every pin, plus one history flop for the
    // edge-detected pins (Sclk, Select, Cal). An edge shows up on the output
    // of the second stage against the history flop, so the FSMs act on it at
    // the third Clock edge after the pin moved.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            hist_q  <= '0;
        end else begin
            sync1_q <= pinsIn;
            sync2_q <= sync1_q;
            hist_q  <= {sync2_q[CAL], sync2_q[SELECT], sync2_q[SCLK]};
        end
    end

    assign sclkRise   =  sync2_q[SCLK]   & ~hist_q[0];
    assign selectFall = ~sync2_q[SELECT] &  hist_q[1];
    assign selectRise =  sync2_q[SELECT] & ~hist_q[1];
    assign calRise    =  sync2_q[CAL]    & ~hist_q[2];
    // Sdata is taken from the same stage as Sclk so both see identical delay
    assign sdataLevel =  sync2_q[SDATA];
    assign pdLevel    =  sync2_q[PD];

    // The bit counter stops at 33 so any overlong frame stays distinguishable
    // from a correct 32-bit one without wrapping back.
    always_comb begin
        bitCount_d = bitCount_q;
        if (bitCount_q != 6'd33) begin
            bitCount_d = bitCount_q + 6'd1;
        end
    end

    // Frame FSM. Select low opens a frame, each Sclk rise shifts a bit in,
    // Select high closes it and CHECK decides in one cycle whether to commit
    // to the register file or flag an error. The strobes are registered, so
    // they appear in the cycle after CHECK. PD high while shifting abandons
    // the frame.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            frameState_q <= F_IDLE;
            shifter_q    <= '0;
            bitCount_q   <= '0;
            regWrite_q   <= 1'b0;
            regAddr_q    <= '0;
            regData_q    <= '0;
            frameError_q <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                regFile_q[i] <= '0;
            end
        end else begin
            regWrite_q   <= 1'b0;
            frameError_q <= 1'b0;
            case (frameState_q)
                F_IDLE: begin
                    if (selectFall && !pdLevel) begin
                        frameState_q <= F_SHIFT;
                        shifter_q    <= '0;
                        bitCount_q   <= '0;
                    end
                end
                F_SHIFT: begin
                    if (pdLevel) begin
                        frameState_q <= F_IDLE;
                        frameError_q <= 1'b1;
                    end else begin
                        if (sclkRise) begin
                            shifter_q  <= {shifter_q[30:0], sdataLevel};
                            bitCount_q <= bitCount_d;
                        end
                        if (selectRise) begin
                            frameState_q <= F_CHECK;
                        end
                    end
                end
                F_CHECK: begin
                    frameState_q <= F_IDLE;
                    if (bitCount_q == 6'd32 && shifter_q[31:20] == HEADER) begin
                        regFile_q[shifter_q[19:16]] <= shifter_q[15:0];
                        regAddr_q  <= shifter_q[19:16];
                        regData_q  <= shifter_q[15:0];
                        regWrite_q <= 1'b1;
                    end else begin
                        frameError_q <= 1'b1;
                    end
                end
                default: begin
                    frameState_q <= F_IDLE;
                end
            endcase
        end
    end

    // Registered read port. A write in the same cycle lands in the array at
    // the same edge, so the old contents are returned and the new value
    // follows one cycle later.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            rdData_q <= '0;
        end else begin
            rdData_q <= regFile_q[RdAddr];
        end
    end

    // Calibration FSM. Only a fresh Cal rise starts it, so a level held high
    // across the end of a run cannot restart it. WAIT burns CAL_DELAY cycles
    // and RUN holds CalRunning for CAL_CYCLES cycles. PD drops straight back
    // to idle from either busy state.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            calState_q   <= CAL_IDLE;
            waitCount_q  <= '0;
            runCount_q   <= '0;
            calRunning_q <= 1'b0;
        end else begin
            case (calState_q)
                CAL_IDLE: begin
                    calRunning_q <= 1'b0;
                    if (calRise && !pdLevel) begin
                        calState_q  <= CAL_WAIT;
                        waitCount_q <= '0;
                    end
                end
                CAL_WAIT: begin
                    if (pdLevel) begin
                        calState_q <= CAL_IDLE;
                    end else if (waitCount_q == WAIT_LAST) begin
                        calState_q   <= CAL_RUN;
                        runCount_q   <= '0;
                        calRunning_q <= 1'b1;
                    end else begin
                        waitCount_q <= waitCount_q + 8'd1;
                    end
                end
                CAL_RUN: begin
                    if (pdLevel || runCount_q == RUN_LAST) begin
                        calState_q   <= CAL_IDLE;
                        calRunning_q <= 1'b0;
                    end else begin
                        runCount_q <= runCount_q + 16'd1;
                    end
                end
                default: begin
                    calState_q   <= CAL_IDLE;
                    calRunning_q <= 1'b0;
                end
            endcase
        end
    end

    assign RdData     = rdData_q;
    assign RegWrite   = regWrite_q;
    assign RegAddr    = regAddr_q;
    assign RegData    = regData_q;
    assign FrameError = frameError_q;
    assign CalRunning = calRunning_q;

endmodule

// File: tb/tb_adc_serial_responder.sv
// ---------------------------------------------------------------------------
// tb_adc_serial_responder
//
// Drives serial frames and Cal/PD levels into adc_serial_responder. Expected
// strobes and calibration pulses are queued when stimulus is issued, and
// independent monitors compare them against what the DUT produces.
// ---------------------------------------------------------------------------
module tb_adc_serial_responder;

    localparam logic [11:0] HEADER     = 12'h001;
    localparam int          CAL_DELAY  = 4;
    localparam int          CAL_CYCLES = 10;

    logic        Clock;
    logic        Reset;
    logic        InSclk;
    logic        InSdata;
    logic        InSelect;
    logic        InCal;
    logic        InPD;
    logic [3:0]  RdAddr;
    logic [15:0] RdData;
    logic        RegWrite;
    logic [3:0]  RegAddr;
    logic [15:0] RegData;
    logic        FrameError;
    logic        CalRunning;

    typedef struct {
        bit          isWrite;
        logic [3:0]  addr;
        logic [15:0] data;
        logic [15:0] oldData;
    } frameExp_t;

    typedef struct {
        int riseCyc;
        int len;
    } calExp_t;

    frameExp_t   frameQ [$];
    calExp_t     calQ [$];
    logic [15:0] model [16];

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    adc_serial_responder #(
        .HEADER    (HEADER),
        .CAL_DELAY (CAL_DELAY),
        .CAL_CYCLES(CAL_CYCLES)
    ) dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .InSclk    (InSclk),
        .InSdata   (InSdata),
        .InSelect  (InSelect),
        .InCal     (InCal),
        .InPD      (InPD),
        .RdAddr    (RdAddr),
        .RdData    (RdData),
        .RegWrite  (RegWrite),
        .RegAddr   (RegAddr),
        .RegData   (RegData),
        .FrameError(FrameError),
        .CalRunning(CalRunning)
    );

    // 10 time-unit clock
    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Free-running cycle count used to time calibration pulses
    always @(posedge Clock) cyc <= cyc + 1;

    // One comparison: counts it and reports any difference
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)",
                     name, actual, expected, cyc);
        end
    endtask

    // Advance n clock edges and settle just past the last one
    task automatic tick(input int n);
        repeat (n) @(posedge Clock);
        #1;
    endtask

    // Frame monitor: every RegWrite or FrameError strobe consumes one
    // expectation. Commits also check the read-port collision behaviour,
    // since RdAddr is pointed at the frame's address while it is sent.
    bit          checkNewPending = 1'b0;
    logic [15:0] newVal;
    frameExp_t   curFrame;
    always @(negedge Clock) begin
        if (checkNewPending) begin
            checkOutput("rd_after_write", RdData, newVal);
            checkNewPending = 1'b0;
        end
        if (RegWrite === 1'b1 || FrameError === 1'b1) begin
            if (frameQ.size() == 0) begin
                vectors++;
                miscompares++;
                $display("[TB] FAIL unexpected_strobe: got RegWrite=%b FrameError=%b, expected no strobe (cycle %0d)",
                         RegWrite, FrameError, cyc);
            end else begin
                curFrame = frameQ.pop_front();
                checkOutput("strobe_kind", {30'b0, RegWrite, FrameError},
                            curFrame.isWrite ? 32'd2 : 32'd1);
                if (curFrame.isWrite) begin
                    checkOutput("reg_addr", RegAddr, curFrame.addr);
                    checkOutput("reg_data", RegData, curFrame.data);
                    checkOutput("rd_collision_old", RdData, curFrame.oldData);
                    newVal          = curFrame.data;
                    checkNewPending = 1'b1;
                end
            end
        end
    end

    // Calibration monitor: each CalRunning pulse must match a queued rise
    // cycle and pulse length; a pulse nobody asked for is a failure.
    logic    calPrev   = 1'b0;
    bit      calActive = 1'b0;
    int      calLen    = 0;
    calExp_t curCal;
    always @(negedge Clock) begin
        if (CalRunning === 1'b1 && calPrev == 1'b0) begin
            calLen = 0;
            if (calQ.size() == 0) begin
                vectors++;
                miscompares++;
                $display("[TB] FAIL unexpected_cal: got CalRunning rise, expected none (cycle %0d)", cyc);
                calActive = 1'b0;
            end else begin
                curCal = calQ.pop_front();
                checkOutput("cal_rise_cycle", cyc, curCal.riseCyc);
                calActive = 1'b1;
            end
        end
        if (CalRunning === 1'b1) calLen++;
        if (CalRunning === 1'b0 && calPrev == 1'b1 && calActive) begin
            checkOutput("cal_length", calLen, curCal.len);
            calActive = 1'b0;
        end
        calPrev = (CalRunning === 1'b1);
    end

    // Send one frame of nbits bits. resetAtBit pulses Reset low for a cycle
    // after that bit, pdAtBit raises PD after that bit; -1 disables either.
    // The expected outcome is queued before the DUT can produce it.
    task automatic applyStimulus(input logic [31:0] word, input int nbits,
                                 input int resetAtBit, input int pdAtBit);
        bit          aborted = 1'b0;
        bit          pdAbort = 1'b0;
        logic [3:0]  addr;
        addr     = word[19:16];
        RdAddr   = addr;
        InSelect = 1'b0;
        tick(4);
        for (int b = 0; b < nbits; b++) begin
            InSdata = (b < 32) ? word[31 - b] : 1'b0;
            InSclk  = 1'b0;
            tick(4);
            InSclk  = 1'b1;
            tick(4);
            if (b == resetAtBit) begin
                Reset = 1'b0;
                for (int i = 0; i < 16; i++) model[i] = 16'h0000;
                tick(1);
                Reset   = 1'b1;
                aborted = 1'b1;
            end
            if (b == pdAtBit) begin
                InPD    = 1'b1;
                pdAbort = 1'b1;
                frameQ.push_back('{isWrite: 1'b0, addr: 4'h0, data: 16'h0, oldData: 16'h0});
            end
        end
        InSclk = 1'b0;
        tick(4);
        if (!aborted && !pdAbort) begin
            if (nbits == 32 && word[31:20] == HEADER) begin
                frameQ.push_back('{isWrite: 1'b1, addr: addr, data: word[15:0],
                                   oldData: model[addr]});
                model[addr] = word[15:0];
            end else begin
                frameQ.push_back('{isWrite: 1'b0, addr: 4'h0, data: 16'h0, oldData: 16'h0});
            end
        end
        InSelect = 1'b1;
        tick(12);
        if (pdAbort) begin
            InPD = 1'b0;
            tick(4);
        end
    endtask

    // Raise Cal for width cycles; when a start is expected, the pulse should
    // rise CAL_DELAY+3 cycles after the pin rise and last len cycles.
    task automatic calPulse(input int width, input bit expectStart, input int len);
        InCal = 1'b1;
        if (expectStart) calQ.push_back('{riseCyc: cyc + CAL_DELAY + 3, len: len});
        tick(width);
        InCal = 1'b0;
    endtask

    // Read back the whole register file against the model
    task automatic checkReads();
        for (int i = 0; i < 16; i++) begin
            RdAddr = 4'(i);
            tick(1);
            checkOutput("rd_data", RdData, model[i]);
        end
    endtask

    // Main sequence: directed scenarios first, then a randomized phase with
    // frames and calibration requests overlapping.
    initial begin
        logic [11:0] hdr;
        logic [31:0] word;
        int          nbits;
        int          r;

        Reset    = 1'b0;
        InSclk   = 1'b0;
        InSdata  = 1'b0;
        InSelect = 1'b1;
        InCal    = 1'b0;
        InPD     = 1'b0;
        RdAddr   = 4'h0;
        for (int i = 0; i < 16; i++) model[i] = 16'h0000;

        tick(3);
        checkOutput("reset_rddata",     RdData,     0);
        checkOutput("reset_regwrite",   RegWrite,   0);
        checkOutput("reset_regaddr",    RegAddr,    0);
        checkOutput("reset_regdata",    RegData,    0);
        checkOutput("reset_frameerror", FrameError, 0);
        checkOutput("reset_calrunning", CalRunning, 0);
        Reset = 1'b1;
        tick(5);

        // Valid frame, bad header, short and long frames
        applyStimulus(32'h0015_ABCD, 32, -1, -1);
        applyStimulus(32'h0025_1234, 32, -1, -1);
        applyStimulus(32'h0017_5555, 31, -1, -1);
        applyStimulus(32'h0018_7777, 33, -1, -1);
        checkReads();

        // Single calibration with a 2-cycle request
        calPulse(2, 1'b1, CAL_CYCLES);
        tick(CAL_DELAY + CAL_CYCLES + 10);

        // Second request during the run must not retrigger or extend
        calPulse(2, 1'b1, CAL_CYCLES);
        tick(CAL_DELAY + 4);
        calPulse(2, 1'b0, 0);
        tick(CAL_CYCLES + 10);

        // PD raised three cycles into the run: pulse shortened to 6 cycles
        calPulse(2, 1'b1, 6);
        tick(CAL_DELAY + 4);
        InPD = 1'b1;
        tick(4);
        checkOutput("cal_pd_abort", CalRunning, 0);
        InPD = 1'b0;
        tick(6);

        // Cal held high past the end of the run must not restart it
        calPulse(CAL_DELAY + CAL_CYCLES + 10, 1'b1, CAL_CYCLES);
        tick(10);

        // Cal requested while powered down is ignored
        InPD = 1'b1;
        tick(4);
        calPulse(2, 1'b0, 0);
        tick(CAL_DELAY + CAL_CYCLES + 6);
        InPD = 1'b0;
        tick(4);

        // PD raised mid-frame abandons it with an error
        applyStimulus(32'h0013_2222, 32, -1, 20);

        // Reset mid-frame: nothing reported, then a clean write to addr 15
        applyStimulus(32'h0019_9999, 32, 17, -1);
        applyStimulus(32'h001F_BEEF, 32, -1, -1);

        // Back-to-back frames to addr 0 and 1
        applyStimulus(32'h0010_1111, 32, -1, -1);
        applyStimulus(32'h0011_2222, 32, -1, -1);
        checkReads();

        // Randomized frames alongside randomized calibration requests
        fork
            begin
                for (int n = 0; n < 14; n++) begin
                    r   = int'($urandom_range(0, 9));
                    hdr = HEADER;
                    if (r == 0) begin
                        hdr = 12'($urandom);
                        if (hdr == HEADER) hdr = hdr ^ 12'h001;
                    end
                    nbits = (r == 1) ? 31 : (r == 2) ? 33 : 32;
                    word  = {hdr, 4'($urandom), 16'($urandom)};
                    applyStimulus(word, nbits, -1, -1);
                end
            end
            begin
                for (int n = 0; n < 6; n++) begin
                    tick(int'($urandom_range(5, 40)));
                    calPulse(int'($urandom_range(1, 4)), 1'b1, CAL_CYCLES);
                    tick(CAL_DELAY + CAL_CYCLES + 8);
                end
            end
        join
        checkReads();
        tick(20);

        checkOutput("frame_queue_empty", frameQ.size(), 0);
        checkOutput("cal_queue_empty",   calQ.size(),   0);
        checkOutput("cal_idle_end",      CalRunning,    0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
